// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the start/stop frame generator.
// Word layout and width helper live here so the formatter and top agree.
package sync_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int out_width(int data_w, int parity_en, int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/sync_word_formatter.sv
// Combinational formatter: start bit, data (LSB first), optional parity,
// then STOP_BITS stop bits at the top of the word.
module sync_word_formatter
  import sync_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int OUT_W     = out_width(DATA_W, PARITY_EN, STOP_BITS)
) (
  input  logic [DATA_W-1:0] data,
  output logic [OUT_W-1:0]  word,
  output logic              parity
);

  assign parity = (PARITY_ODD != 0) ? ~^data : ^data;

  generate
    if (PARITY_EN != 0) begin : g_par
      assign word = {{STOP_BITS{STOP_BIT}}, parity, data, START_BIT};
    end else begin : g_nopar
      assign word = {{STOP_BITS{STOP_BIT}}, data, START_BIT};
    end
  endgenerate

endmodule

// File: rtl/sync_frame_generator_p.sv
// Frame generator: snapshots up to FRAME_LEN words on start, then emits one
// formatted word per valid/ready handshake, with abort and a done pulse.
module sync_frame_generator_p
  import sync_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAME_LEN  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int OUT_W     = out_width(DATA_W, PARITY_EN, STOP_BITS),
  localparam int LEN_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_W-1:0]              frame_len_in,
  input  logic [FRAME_LEN*DATA_W-1:0]   frame_data_in,
  input  logic                          abort,
  output logic [OUT_W-1:0]              frame_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  state_t state, state_nxt;

  logic [FRAME_LEN-1:0][DATA_W-1:0] snap;
  logic [LEN_W-1:0]  len_r, cnt, cnt_nxt, last_idx;
  logic              len_ok, hs, at_last;
  logic              load, adv, fin;
  logic [DATA_W-1:0] next_data, fmt_data;
  logic [OUT_W-1:0]  fmt_word;

  assign len_ok   = (frame_len_in != '0) && (frame_len_in <= LEN_W'(FRAME_LEN));
  assign last_idx = len_r - LEN_W'(1);
  assign at_last  = (cnt == last_idx);
  assign cnt_nxt  = cnt + LEN_W'(1);
  assign hs       = out_valid && out_ready;
  assign busy     = (state != IDLE);

  // Compare-based select keeps the index width independent of FRAME_LEN.
  always_comb begin
    next_data = '0;
    for (int i = 0; i < FRAME_LEN; i++)
      if (cnt_nxt == LEN_W'(i)) next_data = snap[i];
  end

  // On load the first word comes straight from the input bus.
  assign fmt_data = load ? frame_data_in[DATA_W-1:0] : next_data;

  sync_word_formatter #(
    .DATA_W     (DATA_W),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD),
    .STOP_BITS  (STOP_BITS)
  ) u_fmt (
    .data   (fmt_data),
    .word   (fmt_word),
    .parity ()
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start && len_ok) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // abort wins even over a coincident handshake
        if (abort) begin
          state_nxt = IDLE;
        end else if (hs) begin
          if (at_last) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= '0;
      len_r      <= '0;
      cnt        <= '0;
      frame_word <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        snap       <= frame_data_in;
        len_r      <= frame_len_in;
        cnt        <= '0;
        frame_word <= fmt_word;
        out_valid  <= 1'b1;
        out_last   <= (frame_len_in == LEN_W'(1));
      end else if (adv) begin
        cnt        <= cnt_nxt;
        frame_word <= fmt_word;
        out_last   <= (cnt_nxt == last_idx);
      end else if (state_nxt != SEND) begin
        // frame_word keeps its last value; only the qualifiers drop
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_frame_generator_p.sv
// Randomized bench: three generator configurations share stimulus and are
// checked word by word against a frame-level reference model.
module tb_sync_frame_generator_p;

  localparam int DW = 8;
  localparam int FL = 16;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            reset, start, abort, out_ready;
  logic [LW-1:0]   frame_len_in;
  logic [FL*DW-1:0] frame_data_in;

  logic [9:0]  fw0;
  logic [11:0] fw1, fw2;
  logic v0, l0, b0, d0, v1, l1, b1, d1, v2, l2, b2, d2;

  sync_frame_generator_p dut (
    .clk(clk), .reset(reset), .start(start), .frame_len_in(frame_len_in),
    .frame_data_in(frame_data_in), .abort(abort), .frame_word(fw0),
    .out_valid(v0), .out_ready(out_ready), .out_last(l0), .busy(b0), .done(d0)
  );

  sync_frame_generator_p #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
    .clk(clk), .reset(reset), .start(start), .frame_len_in(frame_len_in),
    .frame_data_in(frame_data_in), .abort(abort), .frame_word(fw1),
    .out_valid(v1), .out_ready(out_ready), .out_last(l1), .busy(b1), .done(d1)
  );

  sync_frame_generator_p #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_po (
    .clk(clk), .reset(reset), .start(start), .frame_len_in(frame_len_in),
    .frame_data_in(frame_data_in), .abort(abort), .frame_word(fw2),
    .out_valid(v2), .out_ready(out_ready), .out_last(l2), .busy(b2), .done(d2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] dat [FL];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference word: start bit 0, data LSB first, optional parity, stop bits on top.
  function automatic logic [11:0] fmt(input logic [7:0] d, input bit pe, input bit po, input int sb);
    logic [11:0] w;
    int pos;
    w = '0;
    w[8:1] = d;
    pos = 9;
    if (pe) begin
      w[pos] = (^d) ^ po;
      pos++;
    end
    for (int i = 0; i < sb; i++) w[pos+i] = 1'b1;
    return w;
  endfunction

  task automatic check_word(input int k, input int len);
    chk("valid",   v0,  1);
    chk("word",    fw0, fmt(dat[k], 0, 0, 1));
    chk("last",    l0,  (k == len-1));
    chk("busy",    b0,  1);
    chk("done",    d0,  0);
    chk("word_pe", fw1, fmt(dat[k], 1, 0, 2));
    chk("word_po", fw2, fmt(dat[k], 1, 1, 2));
    chk("last_pe", l1,  (k == len-1));
    chk("valid_po", v2, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, v0, 0);
    chk({tag, "_last"},  l0, 0);
    chk({tag, "_busy"},  b0, 0);
    chk({tag, "_done"},  d0, 0);
    chk({tag, "_valid_pe"}, v1, 0);
    chk({tag, "_busy_po"},  b2, 0);
  endtask

  task automatic pack_dat();
    for (int i = 0; i < FL; i++) frame_data_in[i*DW +: DW] = dat[i];
  endtask

  // mode: 0 always ready, 1 random ready, 2 ready pattern 1-0-0-1
  task automatic run_frame(input int len, input int mode, input int abort_at, input int reset_at);
    int k, stalls, cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    pack_dat();
    frame_len_in = LW'(len);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0; stalls = 0; cyc = 0;
    while (k < len) begin
      check_word(k, len);
      if (len == 1 && dat[0] == 8'h07) begin
        chk("pe_even_word", fw1, 12'hE0E);
        chk("pe_odd_word",  fw2, 12'hC0E);
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check_idle("rst");
        chk("rst_word", fw0, 0);
        chk("rst_word_pe", fw1, 0);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0) || (stalls >= 4);
        default: out_ready = pat[3 - (cyc % 4)];
      endcase
      stalls = out_ready ? 0 : stalls + 1;
      abort = (k == abort_at);
      // Noise on the request side must not disturb the snapshot.
      start = $urandom_range(0, 1);
      frame_len_in = LW'($urandom_range(1, FL));
      for (int i = 0; i < FL; i++) frame_data_in[i*DW +: DW] = DW'($urandom);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (k == abort_at) begin
        check_idle("abort");
        @(posedge clk); @(negedge clk);
        check_idle("abort2");
        return;
      end
      if (out_ready) k++;
    end
    chk("done_valid", v0, 0);
    chk("done_last",  l0, 0);
    chk("done_pulse", d0, 1);
    chk("done_busy",  b0, 1);
    chk("done_pulse_po", d2, 1);
    frame_len_in = LW'(3);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check_idle("after_done");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    frame_len_in = '0; frame_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_word", fw0, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < FL; i++) dat[i] = 8'(8'h10 + i);
    run_frame(16, 0, -1, -1);

    for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
    run_frame(4, 2, -1, -1);

    dat[0] = 8'h07;
    run_frame(1, 0, -1, -1);

    for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
    run_frame(5, 0, 2, -1);
    for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
    run_frame(5, 1, -1, -1);

    for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
    run_frame(8, 0, -1, 3);
    for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
    run_frame(8, 1, -1, -1);

    frame_len_in = '0;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check_idle("len0");
    frame_len_in = LW'(17);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check_idle("len17");

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < FL; i++) dat[i] = 8'($urandom);
      run_frame($urandom_range(1, FL), 1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
